// File: rtl/loader_pkg.sv
// Shared constants for the switch loader: default geometry, derived chunk counts, FSM encodings.
package loader_pkg;

    localparam int DEF_CHUNK_W = 16;
    localparam int NCHUNK      = 4;
    localparam int DEF_DATA_W  = NCHUNK * DEF_CHUNK_W;
    localparam int CHUNK_IDX_W = $clog2(NCHUNK);
    localparam int CNT_W       = CHUNK_IDX_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner and rising-edge pulser. Built with LOADER_DEBOUNCE_EN: 2-flop sync plus
// stability counter, 2+DEB_CYCLES latency; otherwise one history flop, pulse in the high cycle.
module btn_pulse #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

`ifdef LOADER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Any bounce back to the current level restarts the stability count.
        if (sync2_q != level_q) begin
            if (cnt_q == DW'(DEB_CYCLES - 1))
                level_d = sync2_q;
            else
                cnt_d = cnt_q + DW'(1);
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;
`else
    logic prev_q, prev_d;

    assign prev_d = btn_raw;
    assign pulse  = btn_raw & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end
`endif

endmodule

// File: rtl/reg_sw_loader.sv
// Stages a word from switch chunks and issues a one-cycle register-file write; shows a dff slice.
// Pulses act on the next edge, display lags one cycle; no backpressure, dropped pulses are lost.
module reg_sw_loader
    import loader_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = 5,
    parameter int CHUNK_W    = DEF_CHUNK_W,
    parameter int DEB_CYCLES = 16,
    localparam int NCH       = DATA_W / CHUNK_W,
    localparam int IDX_W     = $clog2(NCH),
    localparam int CW        = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHUNK_W-1:0] sw_chunk,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              btn_load,
    input  logic              btn_commit,
    input  logic              btn_clear,
    input  logic [IDX_W-1:0]  disp_sel,
    input  logic [DATA_W-1:0] dff_in,
    output logic [ADDR_W-1:0] swaddr,
    output logic [DATA_W-1:0] swdata,
    output logic              swena,
    output logic [CW-1:0]     chunk_cnt,
    output logic              busy,
    output logic [CHUNK_W-1:0] disp_data
);

    logic load_p, commit_p, clear_p;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_load   (.clk(clk), .rst(rst), .btn_raw(btn_load),   .pulse(load_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_commit (.clk(clk), .rst(rst), .btn_raw(btn_commit), .pulse(commit_p));
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clear  (.clk(clk), .rst(rst), .btn_raw(btn_clear),  .pulse(clear_p));

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  staged_q, staged_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               swena_q, swena_d;
    logic [DATA_W-1:0]  swdata_q, swdata_d;
    logic [ADDR_W-1:0]  swaddr_q, swaddr_d;
    logic [CHUNK_W-1:0] disp_q, disp_d;

    always_comb begin
        state_d  = state_q;
        staged_d = staged_q;
        cnt_d    = cnt_q;
        swena_d  = 1'b0;
        swdata_d = swdata_q;
        swaddr_d = (state_q == ST_WRITE) ? swaddr_q : sw_addr;
        disp_d   = dff_in[disp_sel*CHUNK_W +: CHUNK_W];

        case (state_q)
            ST_IDLE, ST_LOAD, ST_FULL: begin
                if (clear_p && state_q != ST_IDLE) begin
                    state_d  = ST_IDLE;
                    staged_d = '0;
                    cnt_d    = '0;
                end else if (commit_p && state_q != ST_IDLE) begin
                    state_d  = ST_WRITE;
                    swena_d  = 1'b1;
                    swdata_d = staged_q;
                end else if (load_p && state_q != ST_FULL) begin
                    staged_d[cnt_q[IDX_W-1:0]*CHUNK_W +: CHUNK_W] = sw_chunk;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_d == CW'(NCH)) ? ST_FULL : ST_LOAD;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                staged_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            staged_q <= '0;
            cnt_q    <= '0;
            swena_q  <= 1'b0;
            swdata_q <= '0;
            swaddr_q <= '0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            staged_q <= staged_d;
            cnt_q    <= cnt_d;
            swena_q  <= swena_d;
            swdata_q <= swdata_d;
            swaddr_q <= swaddr_d;
            disp_q   <= disp_d;
        end
    end

    assign swaddr    = swaddr_q;
    assign swdata    = swdata_q;
    assign swena     = swena_q;
    assign chunk_cnt = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign disp_data = disp_q;

endmodule
